// File: rtl/sd_spi_rw_test_if.sv
// Handshake bundle between the self-test sequencer and the SD SPI controller.
// master = sequencer side, slave = controller side.
interface sd_spi_rw_test_if;
   logic        wr_start_en;
   logic [31:0] wr_sec_addr;
   logic        wr_req;
   logic [15:0] wr_data;
   logic        wr_busy;
   logic        rd_start_en;
   logic [31:0] rd_sec_addr;
   logic        rd_val_en;
   logic [15:0] rd_val_data;
   logic        rd_busy;

   modport master (
      output wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr,
      input  wr_req, wr_busy, rd_val_en, rd_val_data, rd_busy
   );

   modport slave (
      input  wr_start_en, wr_sec_addr, wr_data, rd_start_en, rd_sec_addr,
      output wr_req, wr_busy, rd_val_en, rd_val_data, rd_busy
   );
endinterface

// File: rtl/sd_spi_rw_test.sv
// SD card write/read-back self-test: writes one sector of SEED+k words, reads it back,
// compares every word and reports a sticky error_flag plus test_done.
module sd_spi_rw_test #(
   parameter logic [31:0] TEST_SECTOR   = 32'd2000,
   parameter logic [15:0] SEED          = 16'h0000,
   parameter logic [8:0]  WORDS_PER_SEC = 9'd256,
   parameter logic [23:0] TIMEOUT_CYC   = 24'd10_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sd_init_done,
   sd_spi_rw_test_if.master  sd,
   output logic              error_flag,
   output logic              test_done
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 9;
   localparam int unsigned TMR_W  = 24;

   typedef enum logic [3:0] {
      IDLE,
      WR_START,
      WR_WAIT_HI,
      WR_WAIT_LO,
      RD_START,
      RD_WAIT_HI,
      RD_WAIT_LO,
      CHECK,
      DONE
   } state_e;

   state_e              state_q,     state_d;
   logic [CNT_W-1:0]    wr_cnt_q,    wr_cnt_d;
   logic [CNT_W-1:0]    rd_cnt_q,    rd_cnt_d;
   logic [TMR_W-1:0]    timer_q,     timer_d;
   logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
   logic                wr_start_q,  wr_start_d;
   logic                rd_start_q,  rd_start_d;
   logic                error_q,     error_d;
   logic                done_q,      done_d;
   logic                wr_busy_q,   wr_busy_d;
   logic                rd_busy_q,   rd_busy_d;

   logic                in_wr_phase;
   logic                in_rd_phase;
   logic                timed_out;
   logic                wr_fall;
   logic                rd_fall;
   logic                err_set;

   // Next-state, counters, compare and flag logic.
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      wr_data_d   = wr_data_q;
      wr_start_d  = 1'b0;
      rd_start_d  = 1'b0;
      wr_busy_d   = sd.wr_busy;
      rd_busy_d   = sd.rd_busy;
      err_set     = 1'b0;

      in_wr_phase = (state_q == WR_WAIT_HI) || (state_q == WR_WAIT_LO);
      in_rd_phase = (state_q == RD_WAIT_HI) || (state_q == RD_WAIT_LO);
      timed_out   = (in_wr_phase || in_rd_phase) && (timer_q == TIMEOUT_CYC - 24'd1);
      wr_fall     = wr_busy_q && !sd.wr_busy;
      rd_fall     = rd_busy_q && !sd.rd_busy;

      // Write data path: each accepted word advances the pattern; overrun only flags.
      if (in_wr_phase && sd.wr_req) begin
         if (wr_cnt_q == WORDS_PER_SEC) begin
            err_set = 1'b1;
         end else begin
            wr_cnt_d  = wr_cnt_q + 9'd1;
            wr_data_d = SEED + DATA_W'(wr_cnt_q) + 16'd1;
         end
      end

      // Read compare against the expected pattern, with overrun detection.
      if (in_rd_phase && sd.rd_val_en) begin
         if (rd_cnt_q == WORDS_PER_SEC) begin
            err_set = 1'b1;
         end else begin
            if (sd.rd_val_data != SEED + DATA_W'(rd_cnt_q)) begin
               err_set = 1'b1;
            end
            rd_cnt_d = rd_cnt_q + 9'd1;
         end
      end

      // Busy edges take priority over a timeout landing in the same cycle.
      unique case (state_q)
         IDLE: begin
            if (sd_init_done) state_d = WR_START;
         end
         WR_START: begin
            wr_start_d = 1'b1;
            wr_cnt_d   = '0;
            wr_data_d  = SEED;
            state_d    = WR_WAIT_HI;
         end
         WR_WAIT_HI: begin
            if (sd.wr_busy) begin
               state_d = WR_WAIT_LO;
            end else if (timed_out) begin
               err_set = 1'b1;
               state_d = DONE;
            end
         end
         WR_WAIT_LO: begin
            if (wr_fall) begin
               state_d = RD_START;
            end else if (timed_out) begin
               err_set = 1'b1;
               state_d = DONE;
            end
         end
         RD_START: begin
            rd_start_d = 1'b1;
            rd_cnt_d   = '0;
            state_d    = RD_WAIT_HI;
         end
         RD_WAIT_HI: begin
            if (sd.rd_busy) begin
               state_d = RD_WAIT_LO;
            end else if (timed_out) begin
               err_set = 1'b1;
               state_d = DONE;
            end
         end
         RD_WAIT_LO: begin
            if (rd_fall) begin
               state_d = CHECK;
            end else if (timed_out) begin
               err_set = 1'b1;
               state_d = DONE;
            end
         end
         CHECK: begin
            if ((wr_cnt_q != WORDS_PER_SEC) || (rd_cnt_q != WORDS_PER_SEC)) begin
               err_set = 1'b1;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Phase timer restarts on every state change and only runs while waiting on busy.
      if ((state_d != state_q) || !(in_wr_phase || in_rd_phase)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 24'd1;
      end

      error_d = error_q | err_set;
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         timer_q    <= '0;
         wr_data_q  <= SEED;
         wr_start_q <= 1'b0;
         rd_start_q <= 1'b0;
         error_q    <= 1'b0;
         done_q     <= 1'b0;
         wr_busy_q  <= 1'b0;
         rd_busy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         timer_q    <= timer_d;
         wr_data_q  <= wr_data_d;
         wr_start_q <= wr_start_d;
         rd_start_q <= rd_start_d;
         error_q    <= error_d;
         done_q     <= done_d;
         wr_busy_q  <= wr_busy_d;
         rd_busy_q  <= rd_busy_d;
      end
   end

   assign sd.wr_start_en = wr_start_q;
   assign sd.wr_sec_addr = TEST_SECTOR;
   assign sd.wr_data     = wr_data_q;
   assign sd.rd_start_en = rd_start_q;
   assign sd.rd_sec_addr = TEST_SECTOR;
   assign error_flag     = error_q;
   assign test_done      = done_q;

endmodule
